// File: rtl/ascon_p_seq.sv
// Iterative Ascon p^a sequencer: latches a 320-bit state and applies one round per clock.
// Optional macro ASCON_UNROLL2_EN chains two rounds per clock.
module ascon_p_seq #(
  parameter int MAX_ROUNDS = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  rounds,
  input  logic [63:0] x0_in,
  input  logic [63:0] x1_in,
  input  logic [63:0] x2_in,
  input  logic [63:0] x3_in,
  input  logic [63:0] x4_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] x0_out,
  output logic [63:0] x1_out,
  output logic [63:0] x2_out,
  output logic [63:0] x3_out,
  output logic [63:0] x4_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);
  localparam logic [3:0] LAST  = 4'(MAX_ROUNDS - 1);

  function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned r);
    return (x >> r) | (x << (64 - r));
  endfunction

  function automatic logic [7:0] rc(input logic [3:0] i);
    return {4'hF - i, i};
  endfunction

  // NOTE: function locals are temporaries, so blocking assignments are correct here.
  function automatic logic [319:0] round_fn(input logic [7:0] c, input logic [319:0] s);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    x2 = x2 ^ {56'd0, c};
    x0 = x0 ^ x4;  x4 = x4 ^ x3;  x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1;  x1 = x1 ^ t2;  x2 = x2 ^ t3;  x3 = x3 ^ t4;  x4 = x4 ^ t0;
    x1 = x1 ^ x0;  x0 = x0 ^ x4;  x3 = x3 ^ x2;  x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  state_t         state, state_nx;
  logic [3:0]     idx;
  logic [3:0]     step;
  logic [3:0]     rounds_eff;
  logic           last;
  logic [319:0]   st_q, out_q, run_nx, r1;
`ifdef ASCON_UNROLL2_EN
  logic [319:0]   r2;
`endif

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    rounds_eff = (rounds > MAX_R) ? MAX_R : rounds;
    r1         = round_fn(rc(idx), st_q);
`ifdef ASCON_UNROLL2_EN
    r2 = round_fn(rc(idx + 4'd1), r1);
    if (idx == LAST) begin
      run_nx = r1;
      step   = 4'd1;
    end else begin
      run_nx = r2;
      step   = 4'd2;
    end
    last = (idx >= LAST - 4'd1);
`else
    run_nx = r1;
    step   = 4'd1;
    last   = (idx == LAST);
`endif
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = (rounds_eff == 4'd0) ? DONE : RUN;
      RUN:  if (last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Datapath registers are cleared on reset so an aborted permutation leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= '0;
      out_q <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          st_q <= {x0_in, x1_in, x2_in, x3_in, x4_in};
          idx  <= MAX_R - rounds_eff;
          if (rounds_eff == 4'd0) out_q <= {x0_in, x1_in, x2_in, x3_in, x4_in};
        end
        RUN: begin
          st_q <= run_nx;
          idx  <= idx + step;
          if (last) out_q <= run_nx;
        end
        default: ;
      endcase
    end
  end

  assign {x0_out, x1_out, x2_out, x3_out, x4_out} = out_q;

endmodule
